// File: rtl/axi_arb_pkg.sv
// Shared constants for the two-master AXI4 arbiter: FSM state encodings
// and the AXI burst/response codes used around it.
package axi_arb_pkg;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ADDR = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_ADDR = 2'd1;
    localparam logic [1:0] WR_DATA = 2'd2;
    localparam logic [1:0] WR_RESP = 2'd3;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_mem_arbiter_rr_grant2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the master the pointer favours.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any = |req;
        if (&req) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter. Read and write paths each serve one
// burst at a time and hand over round-robin when the burst completes.
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    uncoreclk,
    input  logic                    uncore_rstn,

    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [7:0]              s0_axi_awlen,
    input  logic [2:0]              s0_axi_awsize,
    input  logic [1:0]              s0_axi_awburst,
    input  logic [ID_WIDTH-1:0]     s0_axi_awid,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic [ID_WIDTH-1:0]     s0_axi_bid,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [7:0]              s0_axi_arlen,
    input  logic [2:0]              s0_axi_arsize,
    input  logic [1:0]              s0_axi_arburst,
    input  logic [ID_WIDTH-1:0]     s0_axi_arid,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic [ID_WIDTH-1:0]     s0_axi_rid,
    output logic                    s0_axi_rlast,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,

    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [7:0]              s1_axi_awlen,
    input  logic [2:0]              s1_axi_awsize,
    input  logic [1:0]              s1_axi_awburst,
    input  logic [ID_WIDTH-1:0]     s1_axi_awid,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic [ID_WIDTH-1:0]     s1_axi_bid,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [7:0]              s1_axi_arlen,
    input  logic [2:0]              s1_axi_arsize,
    input  logic [1:0]              s1_axi_arburst,
    input  logic [ID_WIDTH-1:0]     s1_axi_arid,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic [ID_WIDTH-1:0]     s1_axi_rid,
    output logic                    s1_axi_rlast,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic                    rd_owner,
    output logic                    wr_owner
);

    logic [1:0] r_rd_state;
    logic       r_rd_owner;
    logic       r_rd_ptr;
    logic       w_rd_gnt;
    logic       w_rd_any;
    logic       w_rd_addr_ph;
    logic       w_rd_data_ph;

    logic [1:0] r_wr_state;
    logic       r_wr_owner;
    logic       r_wr_ptr;
    logic       w_wr_gnt;
    logic       w_wr_any;
    logic       w_wr_addr_ph;
    logic       w_wr_data_ph;
    logic       w_wr_resp_ph;

    rr_grant2 u_rd_rr (
        .req     ({s1_axi_arvalid, s0_axi_arvalid}),
        .ptr     (r_rd_ptr),
        .gnt_idx (w_rd_gnt),
        .any     (w_rd_any)
    );

    rr_grant2 u_wr_rr (
        .req     ({s1_axi_awvalid, s0_axi_awvalid}),
        .ptr     (r_wr_ptr),
        .gnt_idx (w_wr_gnt),
        .any     (w_wr_any)
    );

    // ------------------------------------------------------------ read path
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            r_rd_state <= RD_IDLE;
            r_rd_owner <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_rd_any) begin
                        r_rd_owner <= w_rd_gnt;
                        r_rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // The pointer moves only on completion, so contention alternates.
                    if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                        r_rd_ptr   <= ~r_rd_owner;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign w_rd_addr_ph = (r_rd_state == RD_ADDR);
    assign w_rd_data_ph = (r_rd_state == RD_DATA);

    always_comb begin
        m_axi_araddr   = r_rd_owner ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arlen    = r_rd_owner ? s1_axi_arlen   : s0_axi_arlen;
        m_axi_arsize   = r_rd_owner ? s1_axi_arsize  : s0_axi_arsize;
        m_axi_arburst  = r_rd_owner ? s1_axi_arburst : s0_axi_arburst;
        m_axi_arid     = r_rd_owner ? s1_axi_arid    : s0_axi_arid;
        m_axi_arvalid  = w_rd_addr_ph & (r_rd_owner ? s1_axi_arvalid : s0_axi_arvalid);
        s0_axi_arready = w_rd_addr_ph & ~r_rd_owner & m_axi_arready;
        s1_axi_arready = w_rd_addr_ph &  r_rd_owner & m_axi_arready;

        m_axi_rready   = w_rd_data_ph & (r_rd_owner ? s1_axi_rready : s0_axi_rready);
        s0_axi_rvalid  = w_rd_data_ph & ~r_rd_owner & m_axi_rvalid;
        s1_axi_rvalid  = w_rd_data_ph &  r_rd_owner & m_axi_rvalid;
        s0_axi_rdata   = m_axi_rdata;
        s1_axi_rdata   = m_axi_rdata;
        s0_axi_rresp   = m_axi_rresp;
        s1_axi_rresp   = m_axi_rresp;
        s0_axi_rid     = m_axi_rid;
        s1_axi_rid     = m_axi_rid;
        s0_axi_rlast   = m_axi_rlast;
        s1_axi_rlast   = m_axi_rlast;
    end

    // ----------------------------------------------------------- write path
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            r_wr_state <= WR_IDLE;
            r_wr_owner <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_wr_any) begin
                        r_wr_owner <= w_wr_gnt;
                        r_wr_state <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        r_wr_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        r_wr_ptr   <= ~r_wr_owner;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    assign w_wr_addr_ph = (r_wr_state == WR_ADDR);
    assign w_wr_data_ph = (r_wr_state == WR_DATA);
    assign w_wr_resp_ph = (r_wr_state == WR_RESP);

    // W is only accepted once the owner's AW has gone through; early W stalls.
    always_comb begin
        m_axi_awaddr   = r_wr_owner ? s1_axi_awaddr  : s0_axi_awaddr;
        m_axi_awlen    = r_wr_owner ? s1_axi_awlen   : s0_axi_awlen;
        m_axi_awsize   = r_wr_owner ? s1_axi_awsize  : s0_axi_awsize;
        m_axi_awburst  = r_wr_owner ? s1_axi_awburst : s0_axi_awburst;
        m_axi_awid     = r_wr_owner ? s1_axi_awid    : s0_axi_awid;
        m_axi_awvalid  = w_wr_addr_ph & (r_wr_owner ? s1_axi_awvalid : s0_axi_awvalid);
        s0_axi_awready = w_wr_addr_ph & ~r_wr_owner & m_axi_awready;
        s1_axi_awready = w_wr_addr_ph &  r_wr_owner & m_axi_awready;

        m_axi_wdata    = r_wr_owner ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb    = r_wr_owner ? s1_axi_wstrb : s0_axi_wstrb;
        m_axi_wlast    = r_wr_owner ? s1_axi_wlast : s0_axi_wlast;
        m_axi_wvalid   = w_wr_data_ph & (r_wr_owner ? s1_axi_wvalid : s0_axi_wvalid);
        s0_axi_wready  = w_wr_data_ph & ~r_wr_owner & m_axi_wready;
        s1_axi_wready  = w_wr_data_ph &  r_wr_owner & m_axi_wready;

        m_axi_bready   = w_wr_resp_ph & (r_wr_owner ? s1_axi_bready : s0_axi_bready);
        s0_axi_bvalid  = w_wr_resp_ph & ~r_wr_owner & m_axi_bvalid;
        s1_axi_bvalid  = w_wr_resp_ph &  r_wr_owner & m_axi_bvalid;
        s0_axi_bresp   = m_axi_bresp;
        s1_axi_bresp   = m_axi_bresp;
        s0_axi_bid     = m_axi_bid;
        s1_axi_bid     = m_axi_bid;
    end

    assign rd_owner = r_rd_owner;
    assign wr_owner = r_wr_owner;

endmodule
